// File: rtl/wash_cycle_sequencer.sv
// Stage sequencer for the washing machine: FILL, WASH, DRAIN, RINSE, SPIN with per-stage
// tick durations, pause/door freeze and fill timeout. Define WCS_EXTRA_RINSE_EN for the extra rinse pass.
module wash_cycle_sequencer #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PRESC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             door_closed,
  input  logic             level_full,
`ifdef WCS_EXTRA_RINSE_EN
  input  logic             extra_rinse,
`endif
  input  logic             cfg_we,
  input  logic [2:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  output logic [2:0]       stage,
  output logic             busy,
  output logic             paused,
  output logic             door_lock,
  output logic             valve_on,
  output logic             motor_on,
  output logic             done,
  output logic             err
);

  localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(PRESC - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFill  = 3'd1,
    StWash  = 3'd2,
    StDrain = 3'd3,
    StRinse = 3'd4,
    StSpin  = 3'd5,
    StDone  = 3'd6,
    StError = 3'd7
  } stage_e;

  stage_e           stage_q, stage_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Index 0 is the FILL timeout, 1..4 are WASH, DRAIN, RINSE, SPIN.
  logic [CNT_W-1:0] dur_q [5];
  logic [CNT_W-1:0] dur_d [5];
  logic             rinse2_q, rinse2_d;

  logic             busy_w, frozen, tick, cnt_zero, enter, xr_sample;
  logic [CNT_W-1:0] dur_sel;

`ifdef WCS_EXTRA_RINSE_EN
  assign xr_sample = extra_rinse;
`else
  assign xr_sample = 1'b0;
`endif

  assign busy_w   = (stage_q == StFill) || (stage_q == StWash) || (stage_q == StDrain) ||
                    (stage_q == StRinse) || (stage_q == StSpin);
  assign frozen   = busy_w && (pause || !door_closed);
  assign tick     = busy_w && !frozen && (presc_q == PrescMax);
  assign cnt_zero = (cnt_q == '0);
  assign enter    = (stage_d != stage_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q  <= StIdle;
      presc_q  <= '0;
      cnt_q    <= '0;
      rinse2_q <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        dur_q[i] <= CNT_W'(3);
      end
    end else begin
      stage_q  <= stage_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      rinse2_q <= rinse2_d;
      for (int i = 0; i < 5; i++) begin
        dur_q[i] <= dur_d[i];
      end
    end
  end

  always_comb begin
    stage_d  = stage_q;
    rinse2_d = rinse2_q;
    unique case (stage_q)
      StIdle: begin
        if (start && door_closed && !pause) begin
          stage_d  = StFill;
          rinse2_d = xr_sample;
        end
      end
      StFill: begin
        // A full drum wins over a timeout expiring in the same cycle.
        if (!frozen) begin
          if (level_full)           stage_d = StWash;
          else if (tick && cnt_zero) stage_d = StError;
        end
      end
      StWash:  if (tick && cnt_zero) stage_d = StDrain;
      StDrain: if (tick && cnt_zero) stage_d = StRinse;
      StRinse: begin
        if (tick && cnt_zero) begin
          if (rinse2_q) begin
            stage_d  = StDrain;
            rinse2_d = 1'b0;
          end else begin
            stage_d = StSpin;
          end
        end
      end
      StSpin:  if (tick && cnt_zero) stage_d = StDone;
      StDone:  stage_d = StIdle;
      StError: if (start) stage_d = StIdle;
    endcase
  end

  always_comb begin
    case (stage_d)
      StFill:  dur_sel = dur_q[0];
      StWash:  dur_sel = dur_q[1];
      StDrain: dur_sel = dur_q[2];
      StRinse: dur_sel = dur_q[3];
      StSpin:  dur_sel = dur_q[4];
      default: dur_sel = '0;
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (enter) begin
      presc_d = '0;
      cnt_d   = dur_sel;
    end else if (tick) begin
      presc_d = '0;
      if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);
    end else if (busy_w && !frozen) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      dur_d[i] = dur_q[i];
    end
    if (cfg_we && !busy_w) begin
      case (cfg_sel)
        3'd1:    dur_d[0] = cfg_data;
        3'd2:    dur_d[1] = cfg_data;
        3'd3:    dur_d[2] = cfg_data;
        3'd4:    dur_d[3] = cfg_data;
        3'd5:    dur_d[4] = cfg_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    stage     = stage_q;
    busy      = busy_w;
    paused    = frozen;
    door_lock = busy_w;
    valve_on  = (stage_q == StFill) && !frozen;
    motor_on  = ((stage_q == StWash) || (stage_q == StRinse) || (stage_q == StSpin)) && !frozen;
    done      = (stage_q == StDone);
    err       = (stage_q == StError);
  end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Bench for wash_cycle_sequencer: directed scenarios and random traffic checked each cycle
// against a remaining-cycles model of the wash program.
module tb_wash_cycle_sequencer;

  localparam int P = 2;
`ifdef WCS_EXTRA_RINSE_EN
  localparam bit XR_EN = 1'b1;
`else
  localparam bit XR_EN = 1'b0;
`endif

  logic       clk, reset, start, pause, door_closed, level_full, extra_rinse;
  logic       cfg_we;
  logic [2:0] cfg_sel;
  logic [7:0] cfg_data;
  logic [2:0] stage;
  logic       busy, paused, door_lock, valve_on, motor_on, done, err;

  int vectors, miscompares;

  // Model: current stage, active cycles left in it, and the duration registers.
  logic [2:0] m_stage;
  int         m_left;
  int         m_dur [1:5];
  bit         m_xr;

  wash_cycle_sequencer #(.CNT_W(8), .PRESC(P)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .door_closed (door_closed),
    .level_full  (level_full),
`ifdef WCS_EXTRA_RINSE_EN
    .extra_rinse (extra_rinse),
`endif
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .stage       (stage),
    .busy        (busy),
    .paused      (paused),
    .door_lock   (door_lock),
    .valve_on    (valve_on),
    .motor_on    (motor_on),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] dut_out();
    return {stage, busy, paused, door_lock, valve_on, motor_on, done, err};
  endfunction

  function automatic logic [9:0] exp_out();
    logic b, f;
    b = (m_stage >= 3'd1) && (m_stage <= 3'd5);
    f = b && (pause || !door_closed);
    return {m_stage, b, f, b, (m_stage == 3'd1) && !f,
            ((m_stage == 3'd2) || (m_stage == 3'd4) || (m_stage == 3'd5)) && !f,
            m_stage == 3'd6, m_stage == 3'd7};
  endfunction

  task automatic model_reset();
    m_stage = 3'd0;
    m_left  = 0;
    m_xr    = 1'b0;
    for (int i = 1; i <= 5; i++) m_dur[i] = 3;
  endtask

  task automatic m_enter(input logic [2:0] s);
    m_stage = s;
    m_left  = (m_dur[s] + 1) * P;
  endtask

  task automatic model_step();
    logic b, f;
    if (!reset) begin
      model_reset();
      return;
    end
    b = (m_stage >= 3'd1) && (m_stage <= 3'd5);
    f = b && (pause || !door_closed);
    case (m_stage)
      3'd0: if (start && door_closed && !pause) begin
        m_xr = XR_EN && extra_rinse;
        m_enter(3'd1);
      end
      3'd1: if (!f) begin
        if (level_full) m_enter(3'd2);
        else begin
          m_left--;
          if (m_left == 0) m_stage = 3'd7;
        end
      end
      3'd2, 3'd3, 3'd4, 3'd5: if (!f) begin
        m_left--;
        if (m_left == 0) begin
          if (m_stage == 3'd2) m_enter(3'd3);
          else if (m_stage == 3'd3) m_enter(3'd4);
          else if (m_stage == 3'd4) begin
            if (m_xr) begin
              m_xr = 1'b0;
              m_enter(3'd3);
            end else m_enter(3'd5);
          end else m_stage = 3'd6;
        end
      end
      3'd6: m_stage = 3'd0;
      default: if (start) m_stage = 3'd0;
    endcase
    if (cfg_we && !b && cfg_sel >= 3'd1 && cfg_sel <= 3'd5) m_dur[cfg_sel] = int'(cfg_data);
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_quiet();
    start = 0; pause = 0; door_closed = 1; level_full = 0; extra_rinse = 0;
    cfg_we = 0; cfg_sel = 3'd0; cfg_data = 8'd0;
  endtask

  task automatic cfg_at(input int c, input int at, input logic [2:0] sel, input logic [7:0] d);
    cfg_we = (c == at); cfg_sel = sel; cfg_data = d;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    set_quiet();
    reset = 1'b0;
    #1;
    obs = dut_out();
    vectors++;
    if (obs !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want %b", obs, 10'b0);
    end
    model_reset();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    logic [9:0] obs, expv;
    int hist [8];
    int dones, locks;
    dones = 0; locks = 0;
    for (int i = 0; i < 8; i++) hist[i] = 0;
    set_quiet();
    level_full = 1;
    for (int c = 0; c < 37; c++) begin
      start = (c == 0);
      #1;
      obs = dut_out(); expv = exp_out(); vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL nominal c=%0d got %b want %b", c, obs, expv);
      end
      hist[stage]++; dones += int'(done); locks += int'(door_lock);
      clk_step();
    end
    vectors += 4;
    if (hist[1] !== 1) begin miscompares++; $display("FAIL nominal_fill_len got %0d want 1", hist[1]); end
    if (hist[2] !== 8 || hist[3] !== 8 || hist[4] !== 8 || hist[5] !== 8) begin
      miscompares++;
      $display("FAIL nominal_stage_lens got %0d/%0d/%0d/%0d want 8 each", hist[2], hist[3], hist[4], hist[5]);
    end
    if (dones !== 1) begin miscompares++; $display("FAIL nominal_done_pulses got %0d want 1", dones); end
    if (locks !== 33) begin miscompares++; $display("FAIL nominal_door_lock got %0d want 33", locks); end
    set_quiet();
  endtask

  task automatic test_fill_timeout();
    logic [9:0] obs, expv;
    int hist [8];
    int valves;
    valves = 0;
    for (int i = 0; i < 8; i++) hist[i] = 0;
    set_quiet();
    for (int c = 0; c < 14; c++) begin
      cfg_at(c, 0, 3'd1, 8'd2);
      start = (c == 1) || (c == 11);
      #1;
      obs = dut_out(); expv = exp_out(); vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL fill_timeout c=%0d got %b want %b", c, obs, expv);
      end
      hist[stage]++; valves += int'(valve_on);
      clk_step();
    end
    #1;
    vectors += 3;
    if (hist[1] !== 6) begin miscompares++; $display("FAIL timeout_fill_len got %0d want 6", hist[1]); end
    if (hist[7] !== 4 || valves !== 6) begin
      miscompares++;
      $display("FAIL timeout_error got err=%0d valve=%0d want 4/6", hist[7], valves);
    end
    if (stage !== 3'd0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL error_clear got stage=%0d err=%0b want 0/0", stage, err);
    end
    set_quiet();
  endtask

  task automatic test_pause();
    logic [9:0] obs, expv;
    int hist [8];
    int wash_run, pcnt;
    wash_run = 0; pcnt = 0;
    for (int i = 0; i < 8; i++) hist[i] = 0;
    set_quiet();
    level_full = 1;
    for (int c = 0; c < 52; c++) begin
      cfg_at(c, 0, 3'd2, 8'd5);
      start = (c == 1);
      pause = (c >= 7 && c <= 16);
      #1;
      obs = dut_out(); expv = exp_out(); vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL pause c=%0d got %b want %b", c, obs, expv);
      end
      hist[stage]++; pcnt += int'(paused);
      if (stage == 3'd2 && motor_on) wash_run++;
      clk_step();
    end
    vectors += 2;
    if (hist[2] !== 22 || wash_run !== 12) begin
      miscompares++;
      $display("FAIL pause_wash got total=%0d run=%0d want 22/12", hist[2], wash_run);
    end
    if (pcnt !== 10) begin miscompares++; $display("FAIL pause_flag got %0d want 10", pcnt); end
    set_quiet();
  endtask

  task automatic test_door();
    logic [9:0] obs, expv;
    int hist [8];
    int spin_run, pcnt;
    logic [2:0] idle_st;
    spin_run = 0; pcnt = 0; idle_st = 3'd7;
    for (int i = 0; i < 8; i++) hist[i] = 0;
    set_quiet();
    level_full = 1;
    for (int c = 0; c < 48; c++) begin
      cfg_at(c, 0, 3'd2, 8'd3);
      start = (c == 1) || (c == 44);
      door_closed = !((c >= 29 && c <= 33) || c == 44);
      #1;
      obs = dut_out(); expv = exp_out(); vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL door c=%0d got %b want %b", c, obs, expv);
      end
      hist[stage]++; pcnt += int'(paused);
      if (stage == 3'd5 && motor_on) spin_run++;
      if (c == 45) idle_st = stage;
      clk_step();
    end
    vectors += 3;
    if (hist[5] !== 13 || spin_run !== 8) begin
      miscompares++;
      $display("FAIL door_spin got total=%0d run=%0d want 13/8", hist[5], spin_run);
    end
    if (pcnt !== 5) begin miscompares++; $display("FAIL door_freeze got %0d want 5", pcnt); end
    if (idle_st !== 3'd0) begin
      miscompares++;
      $display("FAIL door_open_start got stage=%0d want 0", idle_st);
    end
    set_quiet();
  endtask

  task automatic test_cfg_busy();
    logic [9:0] obs, expv;
    int hist [8];
    for (int i = 0; i < 8; i++) hist[i] = 0;
    set_quiet();
    level_full = 1;
    for (int c = 0; c < 63; c++) begin
      if (c == 0) cfg_at(c, 0, 3'd4, 8'd0);
      else cfg_at(c, 4, 3'd2, 8'd9);
      start = (c == 1) || (c == 32);
      #1;
      obs = dut_out(); expv = exp_out(); vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL cfg_busy c=%0d got %b want %b", c, obs, expv);
      end
      hist[stage]++;
      clk_step();
    end
    vectors += 2;
    if (hist[2] !== 16) begin miscompares++; $display("FAIL cfg_busy_ignored got %0d want 16", hist[2]); end
    if (hist[4] !== 4) begin miscompares++; $display("FAIL rinse_zero_len got %0d want 4", hist[4]); end
    set_quiet();
  endtask

  task automatic test_reset_mid();
    logic [9:0] obs, expv;
    int hist [8];
    for (int i = 0; i < 8; i++) hist[i] = 0;
    set_quiet();
    level_full = 1;
    for (int c = 0; c < 12; c++) begin
      cfg_at(c, 0, 3'd3, 8'd7);
      start = (c == 1);
      #1;
      obs = dut_out(); expv = exp_out(); vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL reset_mid_pre c=%0d got %b want %b", c, obs, expv);
      end
      clk_step();
    end
    set_quiet();
    #2 reset = 1'b0;
    #1;
    obs = dut_out(); vectors++;
    if (obs !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs got %b want %b", obs, 10'b0);
    end
    model_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    level_full = 1;
    for (int c = 0; c < 37; c++) begin
      start = (c == 0);
      #1;
      obs = dut_out(); expv = exp_out(); vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL reset_mid_post c=%0d got %b want %b", c, obs, expv);
      end
      hist[stage]++;
      clk_step();
    end
    vectors++;
    if (hist[3] !== 8) begin miscompares++; $display("FAIL reset_dur_revert got %0d want 8", hist[3]); end
    set_quiet();
  endtask

`ifdef WCS_EXTRA_RINSE_EN
  task automatic test_extra_rinse();
    logic [9:0] obs, expv;
    logic [2:0] tr [$];
    logic [2:0] want [8];
    logic [2:0] last;
    want = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd5, 3'd6};
    last = 3'd0;
    set_quiet();
    level_full = 1;
    for (int c = 0; c < 55; c++) begin
      start = (c == 0);
      extra_rinse = (c == 0);
      #1;
      obs = dut_out(); expv = exp_out(); vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL extra_rinse c=%0d got %b want %b", c, obs, expv);
      end
      if (stage != last && stage != 3'd0) tr.push_back(stage);
      last = stage;
      clk_step();
    end
    vectors++;
    if (tr.size() != 8) begin
      miscompares++;
      $display("FAIL extra_rinse_trace_len got %0d want 8", tr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (tr[i] !== want[i]) begin
          miscompares++;
          $display("FAIL extra_rinse_trace[%0d] got %0d want %0d", i, tr[i], want[i]);
        end
      end
    end
    set_quiet();
  endtask
`endif

  task automatic test_random();
    logic [9:0] obs, expv;
    for (int c = 0; c < 1500; c++) begin
      start       = ($urandom_range(0, 7) == 0);
      pause       = ($urandom_range(0, 9) == 0);
      door_closed = ($urandom_range(0, 11) != 0);
      level_full  = ($urandom_range(0, 5) == 0);
      extra_rinse = 1'($urandom_range(0, 1));
      cfg_we      = ($urandom_range(0, 5) == 0);
      cfg_sel     = 3'($urandom_range(0, 7));
      cfg_data    = 8'($urandom_range(0, 4));
      #1;
      obs = dut_out(); expv = exp_out(); vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL random c=%0d got %b want %b", c, obs, expv);
      end
      clk_step();
    end
    set_quiet();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    set_quiet();
    model_reset();
    @(negedge clk);
    test_reset();
    test_nominal();
    test_fill_timeout();
    test_pause();
    test_door();
    test_cfg_busy();
    test_reset_mid();
`ifdef WCS_EXTRA_RINSE_EN
    test_extra_rinse();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wash_cycle_sequencer.md
Name: wash_cycle_sequencer

Overview:
Programmable stage sequencer for the automatic washing machine controller. It steps a wash program through FILL, WASH, DRAIN, RINSE and SPIN. Each stage has its own duration, held in a small config register file. It supports pause/resume, a door interlock and a fill-timeout fault, and drives valve/motor enables plus stage/status outputs for the display logic.

Parameters:
CNT_W, 8, width of each stage duration register and of the stage down-counter
PRESC, 4, clk cycles per timebase tick (>=1); all durations count in ticks

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request; starts a cycle from IDLE, clears ERROR
pause  input  1  level; freezes the running program while high
door_closed  input  1  door sensor, 1 = closed
level_full  input  1  water level sensor, 1 = drum full
cfg_we  input  1  duration register write strobe
cfg_sel  input  3  register select: 1=FILL timeout, 2=WASH, 3=DRAIN, 4=RINSE, 5=SPIN; 0/6/7 ignored
cfg_data  input  CNT_W  duration value in ticks
stage  output  3  IDLE=000 FILL=001 WASH=010 DRAIN=011 RINSE=100 SPIN=101 DONE=110 ERROR=111
busy  output  1  high in FILL..SPIN
paused  output  1  high while busy and frozen
door_lock  output  1  high while busy
valve_on  output  1  high in FILL when not frozen
motor_on  output  1  high in WASH/RINSE/SPIN when not frozen
done  output  1  one-cycle pulse on DONE entry
err  output  1  high in ERROR

Behaviour:
- Reset (async, reset=0): stage=IDLE, all outputs 0, prescaler=0, counter=0, all duration registers=3.
- Config: when cfg_we=1 and busy=0, the selected register takes cfg_data on the next edge. Writes while busy and writes to sel 0/6/7 are ignored.
- Timebase: the prescaler counts 0..PRESC-1 only while busy and not frozen. tick=1 in the cycle the prescaler equals PRESC-1, and the prescaler wraps to 0 that cycle. The prescaler clears to 0 on every stage entry.
- Stage entry: the counter loads the stage's duration register.
- Timed stages (WASH, DRAIN, RINSE, SPIN): on tick with counter!=0, decrement. On tick with counter==0, advance to the next stage. Stage length is (dur+1)*PRESC cycles.
- Duration 0: the stage still lasts PRESC cycles. No stage is skipped.
- FILL: advances to WASH on the first non-frozen cycle with level_full=1; this takes priority over timeout. If tick arrives with counter==0 and level_full=0, go to ERROR.
- Order: IDLE -> FILL -> WASH -> DRAIN -> RINSE -> SPIN -> DONE -> IDLE. DONE lasts exactly 1 cycle with done=1.
- Start: accepted only in IDLE with door_closed=1 and pause=0; next cycle stage=FILL. In all other cases start is ignored, except in ERROR, where start returns to IDLE (err falls the next cycle).
- Freeze: frozen = busy & (pause | ~door_closed). While frozen, stage, counter and prescaler hold; valve_on=motor_on=0; paused=1; level_full is ignored. Resume continues with the exact remaining count and prescaler phase.
- Simultaneous events: a freeze takes precedence over tick/advance in the same cycle. Config writes during DONE/ERROR/IDLE are allowed (busy=0).
- Outputs are registered or decoded from registered state only. No combinational path from inputs to outputs except via paused/valve_on/motor_on gating by frozen (combinational allowed).
- Reset mid-operation: immediate return to the reset state. Duration registers revert to 3.

Optional Feature:
WCS_EXTRA_RINSE_EN: adds input extra_rinse (1 bit), sampled on start acceptance. If the sample was 1, the order becomes ...RINSE -> DRAIN -> RINSE -> SPIN. Both passes use the same RINSE/DRAIN durations, and an internal pass flag selects the second-pass path. Without the macro: no port and a single rinse pass; behaviour is identical to the sample being 0.

Test Plan:
- Reset defaults, PRESC=2, level_full tied 1 after 1 cycle in FILL: start -> FILL 1 cycle, WASH/DRAIN/RINSE/SPIN 8 cycles each, DONE 1 cycle with done=1, then IDLE. busy/door_lock high from FILL through SPIN.
- FILL timeout=2, level_full=0, PRESC=2: stage=ERROR after 6 cycles in FILL, err=1, valve_on falls. start -> IDLE, err=0.
- WASH dur=5, pause high for 10 cycles after 4 WASH cycles: stage holds 010, motor_on=0, paused=1. After release, WASH completes in 8 more cycles (12 total).
- door_closed=0 mid-SPIN: same freeze as pause. start with door_closed=0 in IDLE: stays IDLE.
- cfg_we while busy (sel=2, data=9): ignored, and the next cycle still uses the old WASH duration. Write 0 to RINSE in IDLE: RINSE lasts exactly PRESC cycles.
- With WCS_EXTRA_RINSE_EN, extra_rinse=1 at start: stage trace 001,010,011,100,011,100,101,110.
